// File: rtl/flog_pkg.sv
// Shared constants and payload type for the BFLOAT16 log (FLOG) datapath stages.
package flog_pkg;

  localparam int FLOG_EXP_W = 8;
  localparam int FLOG_MAN_W = 7;
  localparam int FLOG_DW    = 1 + FLOG_EXP_W + FLOG_MAN_W;

  localparam logic [FLOG_DW-1:0] PLUS_INF  = 16'h7f80;
  localparam logic [FLOG_DW-1:0] MINUS_INF = 16'hff80;
  localparam logic [FLOG_DW-1:0] QNAN      = 16'h7fc0;
  localparam logic [FLOG_DW-1:0] PLUS_ZERO = 16'h0000;
  localparam logic [FLOG_DW-1:0] PLUS_ONE  = 16'h3f80;

  typedef struct packed {
    logic               special;
    logic [FLOG_DW-1:0] res;
    logic               nv;
    logic               dz;
  } flog_sres_t;

endpackage

// File: rtl/flog_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer; ready_o comes straight from state,
// so there is no combinational path from ready_i to ready_o.
module flog_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  // State bits are {main_valid, skid_valid}.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  logic [1:0]       state_p1;
  logic [WIDTH-1:0] main_data_p1;
  logic [WIDTH-1:0] skid_data_p1;
  logic             in_fire;
  logic             out_fire;

  assign ready_o  = ~state_p1[0];
  assign valid_o  = state_p1[1];
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // ---- stage p1: entry state ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state_p1 <= EMPTY;
    end else begin
      case (state_p1)
        EMPTY:   if (in_fire) state_p1 <= ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_p1 <= FULL;
          else if (!in_fire && out_fire) state_p1 <= EMPTY;
        end
        FULL:    if (out_fire) state_p1 <= ONE;
        default: state_p1 <= EMPTY;
      endcase
    end
  end

  // Payload registers are never reset; validity alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (state_p1 == FULL) begin
      if (out_fire) main_data_p1 <= skid_data_p1;
    end else if (in_fire && (state_p1 == EMPTY || out_fire)) begin
      main_data_p1 <= data_i;
    end
    if (in_fire && state_p1 == ONE && !out_fire) skid_data_p1 <= data_i;
  end

  assign data_o = valid_o ? main_data_p1 : '0;

endmodule

// File: rtl/flog_special_result_stage.sv
// Resolves log() special-case results ahead of the FLOG core and registers
// them, with the exception flags, through a 2-entry skid buffer.
module flog_special_result_stage
  import flog_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int FTZ   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   s_op_i,
  input  logic [EXP_W-1:0]       exp_op_i,
  input  logic [MAN_W-1:0]       man_op_i,
  input  logic                   isInf_i,
  input  logic                   isZero_i,
  input  logic                   isNaN_i,
  input  logic                   isSNaN_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   special_o,
  output logic [EXP_W+MAN_W:0]   res_o,
  output logic                   nv_o,
  output logic                   dz_o
);

  localparam int DW = 1 + EXP_W + MAN_W;

  logic [DW-1:0] op_p0;
  logic          sub_p0;
  logic          ftz_zero_p0;
  flog_sres_t    sel_p0;
  flog_sres_t    out_p1;

  assign op_p0       = {s_op_i, exp_op_i, man_op_i};
  assign sub_p0      = (exp_op_i == '0) && (man_op_i != '0);
  assign ftz_zero_p0 = isZero_i || ((FTZ != 0) && sub_p0);

  // ---- stage p0: special-result selection, highest priority first ----
  always_comb begin
    sel_p0.special = 1'b1;
    sel_p0.res     = op_p0;
    sel_p0.nv      = 1'b0;
    sel_p0.dz      = 1'b0;
    if (isNaN_i) begin
      sel_p0.res = QNAN;
      sel_p0.nv  = isSNaN_i;
    end else if (ftz_zero_p0) begin
      sel_p0.res = MINUS_INF;
      sel_p0.dz  = 1'b1;
    end else if (s_op_i) begin
      sel_p0.res = QNAN;
      sel_p0.nv  = 1'b1;
    end else if (isInf_i) begin
      sel_p0.res = PLUS_INF;
    end else if (op_p0 == PLUS_ONE) begin
      sel_p0.res = PLUS_ZERO;
    end else begin
      sel_p0.special = 1'b0;
    end
  end

  // ---- stage p1: registered output through the skid buffer ----
  flog_skid_buffer #(
    .WIDTH($bits(flog_sres_t))
  ) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (sel_p0),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (out_p1)
  );

  assign special_o = out_p1.special;
  assign res_o     = out_p1.res;
  assign nv_o      = out_p1.nv;
  assign dz_o      = out_p1.dz;

endmodule

// File: tb/tb_flog_special_result_stage.sv
// Randomized and directed checks of flog_special_result_stage against a
// queue-based reference model of the result rules and 2-entry buffering.
module tb_flog_special_result_stage;

  localparam int FTZ = 1;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        s_op_i = 1'b0;
  logic [7:0]  exp_op_i = '0;
  logic [6:0]  man_op_i = '0;
  logic        isInf_i = 1'b0, isZero_i = 1'b0, isNaN_i = 1'b0, isSNaN_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        special_o;
  logic [15:0] res_o;
  logic        nv_o;
  logic        dz_o;

  always #5 clk = ~clk;

  flog_special_result_stage #(.EXP_W(8), .MAN_W(7), .FTZ(FTZ)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .s_op_i(s_op_i), .exp_op_i(exp_op_i), .man_op_i(man_op_i),
    .isInf_i(isInf_i), .isZero_i(isZero_i), .isNaN_i(isNaN_i), .isSNaN_i(isSNaN_i),
    .valid_o(valid_o), .ready_i(ready_i), .special_o(special_o), .res_o(res_o),
    .nv_o(nv_o), .dz_o(dz_o)
  );

  typedef logic [18:0] sres_t;  // {special, res[15:0], nv, dz}

  int    n_tests = 0;
  int    n_fail  = 0;
  sres_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // log() special-case rules evaluated directly on the raw bfloat16 value.
  function automatic sres_t ref_res(input logic [15:0] op);
    logic [7:0] e;
    logic [6:0] m;
    e = op[14:7];
    m = op[6:0];
    if (e == 8'hff && m != 0)                 return {1'b1, 16'h7fc0, ~m[6], 1'b0};
    if (e == 8'h00 && (m == 0 || FTZ != 0))   return {1'b1, 16'hff80, 1'b0, 1'b1};
    if (op[15])                               return {1'b1, 16'h7fc0, 1'b1, 1'b0};
    if (op == 16'h7f80)                       return {1'b1, 16'h7f80, 1'b0, 1'b0};
    if (op == 16'h3f80)                       return {1'b1, 16'h0000, 1'b0, 1'b0};
    return {1'b0, op, 1'b0, 1'b0};
  endfunction

  // One clock of stimulus; class flags emulate the upstream detector.
  task automatic cycle(input bit v, input logic [15:0] op, input bit rdy,
                       input bit fl, input bit rstn);
    @(posedge clk);
    #1;
    valid_i  = v;
    ready_i  = rdy;
    flush_i  = fl;
    rst_ni   = rstn;
    {s_op_i, exp_op_i, man_op_i} = op;
    isZero_i = (op[14:0] == 0);
    isInf_i  = (op[14:7] == 8'hff) && (op[6:0] == 0);
    isNaN_i  = (op[14:7] == 8'hff) && (op[6:0] != 0);
    isSNaN_i = isNaN_i && !op[6];
  endtask

  // Scoreboard: compare against the model, then advance it across the next edge.
  always @(negedge clk) begin
    bit acc;
    chk("valid_o", valid_o, q.size() != 0);
    chk("ready_o", ready_o, q.size() < 2);
    if (q.size() != 0) chk("payload", {special_o, res_o, nv_o, dz_o}, q[0]);
    if (!rst_ni || flush_i) begin
      q.delete();
    end else begin
      acc = valid_i && (q.size() < 2);
      if (ready_i && q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back(ref_res({s_op_i, exp_op_i, man_op_i}));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".valid_o"}, valid_o, 0);
    chk({tag, ".ready_o"}, ready_o, 1);
    chk({tag, ".special_o"}, special_o, 0);
    chk({tag, ".res_o"}, res_o, 0);
    chk({tag, ".nv_o"}, nv_o, 0);
    chk({tag, ".dz_o"}, dz_o, 0);
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] sp [10];
    sp = '{16'h0000, 16'h8000, 16'h0001, 16'h7fc1, 16'h7f81,
           16'hbf80, 16'h7f80, 16'h3f80, 16'hff80, 16'h8005};
    if ($urandom_range(0, 9) < 4) return sp[$urandom_range(0, 9)];
    return 16'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d_op  [9];
    sres_t       d_exp [9];
    d_op  = '{16'h0000, 16'h8000, 16'h0001, 16'h7fc1, 16'h7f81,
              16'hbf80, 16'h7f80, 16'h3f80, 16'h4000};
    d_exp = '{{1'b1, 16'hff80, 1'b0, 1'b1}, {1'b1, 16'hff80, 1'b0, 1'b1},
              {1'b1, 16'hff80, 1'b0, 1'b1}, {1'b1, 16'h7fc0, 1'b0, 1'b0},
              {1'b1, 16'h7fc0, 1'b1, 1'b0}, {1'b1, 16'h7fc0, 1'b1, 1'b0},
              {1'b1, 16'h7f80, 1'b0, 1'b0}, {1'b1, 16'h0000, 1'b0, 1'b0},
              {1'b0, 16'h4000, 1'b0, 1'b0}};

    cycle(0, 16'h0, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 1);
    @(negedge clk);
    chk_reset_outputs("reset");

    // Back-to-back directed vectors, one cycle latency.
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) cycle(1, d_op[i], 1, 0, 1);
      else       cycle(0, 16'h0, 1, 0, 1);
      @(negedge clk);
      if (i > 0) chk($sformatf("dir%0d", i - 1), {special_o, res_o, nv_o, dz_o}, d_exp[i - 1]);
    end

    // Backpressure: three offered, two accepted, then drain and full rate.
    cycle(1, 16'h4040, 0, 0, 1);
    cycle(1, 16'h3f80, 0, 0, 1);
    cycle(1, 16'h8000, 0, 0, 1);
    @(negedge clk);
    chk("bp.ready_low", ready_o, 0);
    cycle(1, 16'h8000, 1, 0, 1);
    cycle(1, 16'h8000, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 16'h4100 + 16'(i), 1, 0, 1);
      @(negedge clk);
      if (i > 0) chk("bp.throughput", {valid_o, ready_o}, 2'b11);
    end
    cycle(0, 16'h0, 1, 0, 1);
    cycle(0, 16'h0, 1, 0, 1);

    // Flush while FULL, then flush while ONE with a same-cycle input.
    cycle(1, 16'h4200, 0, 0, 1);
    cycle(1, 16'h4201, 0, 0, 1);
    cycle(1, 16'h4202, 0, 1, 1);
    cycle(0, 16'h0, 0, 0, 1);
    @(negedge clk);
    chk("flush_full.valid_o", valid_o, 0);
    chk("flush_full.ready_o", ready_o, 1);
    cycle(1, 16'h4300, 0, 0, 1);
    cycle(1, 16'h4301, 0, 1, 1);
    cycle(0, 16'h0, 1, 0, 1);
    @(negedge clk);
    chk("flush_one.valid_o", valid_o, 0);

    // Reset mid-stream.
    cycle(1, 16'h4400, 0, 0, 1);
    cycle(1, 16'h4401, 0, 0, 1);
    cycle(1, 16'h4402, 1, 0, 0);
    cycle(1, 16'h4080, 1, 0, 1);
    @(negedge clk);
    chk_reset_outputs("midreset");
    cycle(0, 16'h0, 1, 0, 1);
    @(negedge clk);
    chk("midreset.first_valid", valid_o, 1);
    chk("midreset.first_res", res_o, 16'h4080);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd_op(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0, $urandom_range(0, 127) != 0);
    end
    cycle(0, 16'h0, 1, 0, 1);
    cycle(0, 16'h0, 1, 0, 1);
    cycle(0, 16'h0, 1, 0, 1);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
